// File: rtl/ad_frame_sequencer.sv
// AD1868 serial bus sequencer and lock controller, clocked by the I2S master clock.
// Synchronizes the AD bus, deserializes 16-bit stereo words, checks frame length at
// every latch boundary and only releases samples after a run of well-formed frames.
// Optional feature macro: AD_SOFT_MUTE_EN (ramped attenuation after lock).

module ad_frame_sequencer #(
  parameter int unsigned P_BITS_PER_FRAME = 32,
  parameter int unsigned P_LOCK_FRAMES    = 4,
  parameter int unsigned P_TIMEOUT        = 64
) (
  input  logic        i_mclk,
  input  logic        i_rst_x,
  input  logic        i_ad_clk,
  input  logic        i_ad_latch,
  input  logic        i_ad_data_l,
  input  logic        i_ad_data_r,
  output logic [15:0] o_data_l,
  output logic [15:0] o_data_r,
  output logic        o_valid,
  output logic        o_locked,
  output logic        o_mute
);

  localparam int unsigned WdW = $clog2(P_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StAcquire, StLocked} state_e;

  // Bit order in the sync vectors: {clk, latch, data_l, data_r}
  logic [3:0]     sync1_q, sync1_d, sync2_q, sync2_d;
  logic           clk_sync3_q, clk_sync3_d;

  logic           ad_edge, latch_s, data_l_s, data_r_s, boundary, frame_ok, wd_expire;

  logic           latch_prev_q, latch_prev_d;
  logic [15:0]    sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic [5:0]     bit_cnt_q, bit_cnt_d;
  logic [WdW-1:0] wd_q, wd_d;

  state_e         state_q, state_d;
  logic [3:0]     good_q, good_d;

  logic [15:0]    data_l_q, data_l_d, data_r_q, data_r_d;
  logic           valid_q, valid_d;
  logic           leaving_lock;

`ifdef AD_SOFT_MUTE_EN
  logic [3:0]     shift_q, shift_d;
`endif

  // Two-flop synchronizer on all AD inputs, plus a third flop on the clock for edge detect
  always_comb begin
    sync1_d     = {i_ad_clk, i_ad_latch, i_ad_data_l, i_ad_data_r};
    sync2_d     = sync1_q;
    clk_sync3_d = sync2_q[3];
  end

  // Synchronizer registers
  always_ff @(posedge i_mclk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      clk_sync3_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      clk_sync3_q <= clk_sync3_d;
    end
  end

  assign ad_edge  = sync2_q[3] & ~clk_sync3_q;
  assign latch_s  = sync2_q[2];
  assign data_l_s = sync2_q[1];
  assign data_r_s = sync2_q[0];
  assign boundary = ad_edge & latch_s & ~latch_prev_q;
  assign frame_ok = (bit_cnt_q == 6'(P_BITS_PER_FRAME));
  // An AD edge in the expiry cycle wins over the watchdog
  assign wd_expire = ~ad_edge & (wd_q >= WdW'(P_TIMEOUT - 1));

  // Deserializer, frame bit counter and watchdog next-state
  always_comb begin
    latch_prev_d = latch_prev_q;
    sh_l_d       = sh_l_q;
    sh_r_d       = sh_r_q;
    bit_cnt_d    = bit_cnt_q;
    wd_d         = wd_q;
    if (ad_edge) begin
      latch_prev_d = latch_s;
      sh_l_d       = {sh_l_q[14:0], data_l_s};
      sh_r_d       = {sh_r_q[14:0], data_r_s};
      wd_d         = '0;
      if (boundary) begin
        bit_cnt_d = 6'd1;
      end else if (bit_cnt_q != 6'd63) begin
        bit_cnt_d = bit_cnt_q + 6'd1;
      end
    end else if (wd_q != WdW'(P_TIMEOUT)) begin
      wd_d = wd_q + WdW'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge i_mclk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      latch_prev_q <= 1'b0;
      sh_l_q       <= '0;
      sh_r_q       <= '0;
      bit_cnt_q    <= '0;
      wd_q         <= '0;
    end else begin
      latch_prev_q <= latch_prev_d;
      sh_l_q       <= sh_l_d;
      sh_r_q       <= sh_r_d;
      bit_cnt_q    <= bit_cnt_d;
      wd_q         <= wd_d;
    end
  end

  // FSM state register
  always_ff @(posedge i_mclk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      state_q <= StIdle;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // FSM next-state: the first boundary after IDLE only starts counting
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    if (wd_expire) begin
      state_d = StIdle;
      good_d  = '0;
    end else if (boundary) begin
      unique case (state_q)
        StIdle: begin
          state_d = StAcquire;
          good_d  = '0;
        end
        StAcquire: begin
          if (!frame_ok) begin
            good_d = '0;
          end else if (good_q + 4'd1 >= 4'(P_LOCK_FRAMES)) begin
            state_d = StLocked;
            good_d  = '0;
          end else begin
            good_d = good_q + 4'd1;
          end
        end
        StLocked: begin
          if (!frame_ok) begin
            state_d = StAcquire;
            good_d  = '0;
          end
        end
        default: begin
          state_d = StIdle;
          good_d  = '0;
        end
      endcase
    end
  end

  assign leaving_lock = (state_q == StLocked) && (state_d != StLocked);

  // FSM outputs: sample words, strobe and attenuation at boundaries
  always_comb begin
    data_l_d = data_l_q;
    data_r_d = data_r_q;
    valid_d  = 1'b0;
`ifdef AD_SOFT_MUTE_EN
    shift_d  = shift_q;
`endif
    if (leaving_lock) begin
      // Silence immediately, no strobe
      data_l_d = '0;
      data_r_d = '0;
`ifdef AD_SOFT_MUTE_EN
      shift_d  = 4'd15;
`endif
    end else if (boundary && (state_q != StIdle)) begin
      valid_d = 1'b1;
      if (state_d == StLocked) begin
`ifdef AD_SOFT_MUTE_EN
        if (state_q != StLocked) begin
          shift_d = 4'd15;
        end else if (shift_q != 4'd0) begin
          shift_d = shift_q - 4'd1;
        end
        data_l_d = 16'($signed(sh_l_q) >>> shift_d);
        data_r_d = 16'($signed(sh_r_q) >>> shift_d);
`else
        data_l_d = sh_l_q;
        data_r_d = sh_r_q;
`endif
      end else begin
        data_l_d = '0;
        data_r_d = '0;
      end
    end
  end

  // Output registers
  always_ff @(posedge i_mclk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      data_l_q <= '0;
      data_r_q <= '0;
      valid_q  <= 1'b0;
`ifdef AD_SOFT_MUTE_EN
      shift_q  <= 4'd15;
`endif
    end else begin
      data_l_q <= data_l_d;
      data_r_q <= data_r_d;
      valid_q  <= valid_d;
`ifdef AD_SOFT_MUTE_EN
      shift_q  <= shift_d;
`endif
    end
  end

  assign o_data_l = data_l_q;
  assign o_data_r = data_r_q;
  assign o_valid  = valid_q;
  assign o_locked = (state_q == StLocked);
`ifdef AD_SOFT_MUTE_EN
  assign o_mute   = (state_q != StLocked) || (shift_q != 4'd0);
`else
  assign o_mute   = ~o_locked;
`endif

endmodule

// File: tb/tb_ad_frame_sequencer.sv
// Directed testbench for ad_frame_sequencer. AD bits are 16 mclk cycles long
// (8 low, 8 high); each frame starts with its latch (boundary) bit.

module tb_ad_frame_sequencer;

`ifdef AD_SOFT_MUTE_EN
  localparam bit Soft = 1'b1;
`else
  localparam bit Soft = 1'b0;
`endif

  logic        mclk = 1'b0;
  logic        rst_x = 1'b1;
  logic        ad_clk = 1'b0, ad_latch = 1'b0, ad_l = 1'b0, ad_r = 1'b0;
  logic [15:0] data_l, data_r;
  logic        valid, locked, mute;

  int checks = 0;
  int failures = 0;

  // Valid-strobe log and lock-fall log
  logic [15:0] q_l[$], q_r[$];
  logic        q_lk[$], q_mu[$];
  int          fall_cnt = 0;
  logic [15:0] fall_l = '0, fall_r = '0;
  logic        lk_prev = 1'b0;

  ad_frame_sequencer dut (
    .i_mclk      (mclk),
    .i_rst_x     (rst_x),
    .i_ad_clk    (ad_clk),
    .i_ad_latch  (ad_latch),
    .i_ad_data_l (ad_l),
    .i_ad_data_r (ad_r),
    .o_data_l    (data_l),
    .o_data_r    (data_r),
    .o_valid     (valid),
    .o_locked    (locked),
    .o_mute      (mute)
  );

  always #5 mclk = ~mclk;

  always @(negedge mclk) begin
    if (valid === 1'b1) begin
      q_l.push_back(data_l);
      q_r.push_back(data_r);
      q_lk.push_back(locked);
      q_mu.push_back(mute);
    end
    if (lk_prev && (locked !== 1'b1)) begin
      fall_cnt <= fall_cnt + 1;
      fall_l   <= data_l;
      fall_r   <= data_r;
    end
    lk_prev <= (locked === 1'b1);
  end

  function automatic logic [15:0] exp_w(input logic [15:0] w, input int sh);
    return Soft ? 16'($signed(w) >>> sh) : w;
  endfunction

  task automatic send_bit(input logic l, input logic r, input logic la);
    ad_l = l;
    ad_r = r;
    ad_latch = la;
    ad_clk = 1'b0;
    repeat (8) @(negedge mclk);
    ad_clk = 1'b1;
    repeat (8) @(negedge mclk);
  endtask

  // n bits; the last 16 carry the word MSB first; bit 0 carries the latch
  task automatic send_frame(input int n, input logic [15:0] wl, input logic [15:0] wr);
    int idx;
    for (int i = 0; i < n; i++) begin
      idx = n - 1 - i;
      if (idx < 16) send_bit(wl[idx[3:0]], wr[idx[3:0]], i == 0);
      else send_bit(1'b0, 1'b0, i == 0);
    end
  endtask

  // Check a logged strobe against lock flag and soft-mute shift
  task automatic chk_entry(input string name, input int i, input logic lk, input int sh,
                           input logic [15:0] wl, input logic [15:0] wr);
    logic [15:0] el, er;
    logic        em;
    el = lk ? exp_w(wl, sh) : 16'h0;
    er = lk ? exp_w(wr, sh) : 16'h0;
    em = lk ? (Soft && sh != 0) : 1'b1;
    checks++;
    if (i >= q_l.size()) begin
      failures++;
      $display("FAIL %s[%0d]: strobe missing, got %0d strobes", name, i, q_l.size());
    end else if ({q_lk[i], q_mu[i], q_l[i], q_r[i]} !== {lk, em, el, er}) begin
      failures++;
      $display("FAIL %s[%0d]: got lk=%b mu=%b l=%h r=%h exp lk=%b mu=%b l=%h r=%h", name, i,
               q_lk[i], q_mu[i], q_l[i], q_r[i], lk, em, el, er);
    end
  endtask

  task automatic test_reset();
    rst_x = 1'b0;
    repeat (3) @(negedge mclk);
    checks++;
    if ({data_l, data_r, valid, locked, mute} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_values: got l=%h r=%h v=%b lk=%b mu=%b exp 0 0 0 0 1",
               data_l, data_r, valid, locked, mute);
    end
    rst_x = 1'b1;
  endtask

  task automatic test_idle();
    int base;
    base = q_l.size();
    repeat (200) @(negedge mclk);
    checks++;
    if (q_l.size() != base) begin
      failures++;
      $display("FAIL idle_no_valid: got %0d strobes exp 0", q_l.size() - base);
    end
    checks++;
    if ({data_l, data_r, locked, mute} !== {32'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL idle_outputs: got l=%h r=%h lk=%b mu=%b exp 0 0 0 1",
               data_l, data_r, locked, mute);
    end
  endtask

  task automatic test_lock();
    int base;
    base = q_l.size();
    repeat (6) send_frame(32, 16'h1234, 16'hFEDC);
    checks++;
    if (q_l.size() - base != 5) begin
      failures++;
      $display("FAIL lock_strobes: got %0d exp 5", q_l.size() - base);
    end
    for (int k = 0; k < 5; k++)
      chk_entry("lock", base + k, k >= 3, (k == 3) ? 15 : 14, 16'h1234, 16'hFEDC);
  endtask

  task automatic test_bad_frame();
    int base, fbase;
    base  = q_l.size();
    fbase = fall_cnt;
    send_frame(31, 16'h1234, 16'hFEDC);
    repeat (5) send_frame(32, 16'h1234, 16'hFEDC);
    checks++;
    if (q_l.size() - base != 5) begin
      failures++;
      $display("FAIL bad_strobes: got %0d exp 5", q_l.size() - base);
    end
    chk_entry("bad_pre", base, 1'b1, 13, 16'h1234, 16'hFEDC);
    for (int k = 1; k < 4; k++) chk_entry("bad_acq", base + k, 1'b0, 0, 16'h1234, 16'hFEDC);
    chk_entry("bad_relock", base + 4, 1'b1, 15, 16'h1234, 16'hFEDC);
    checks++;
    if ((fall_cnt - fbase != 1) || ({fall_l, fall_r} !== 32'h0)) begin
      failures++;
      $display("FAIL bad_unlock: got falls=%0d l=%h r=%h exp 1 0000 0000",
               fall_cnt - fbase, fall_l, fall_r);
    end
  endtask

  task automatic test_timeout();
    int base, fbase;
    base  = q_l.size();
    fbase = fall_cnt;
    ad_clk = 1'b0;
    repeat (40) @(negedge mclk);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early: got locked=%b exp 1", locked);
    end
    repeat (40) @(negedge mclk);
    checks++;
    if ({data_l, data_r, locked, mute} !== {32'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL timeout_idle: got l=%h r=%h lk=%b mu=%b exp 0 0 0 1",
               data_l, data_r, locked, mute);
    end
    checks++;
    if ((q_l.size() != base) || (fall_cnt - fbase != 1) || ({fall_l, fall_r} !== 32'h0)) begin
      failures++;
      $display("FAIL timeout_drop: got strobes=%0d falls=%0d l=%h r=%h exp 0 1 0000 0000",
               q_l.size() - base, fall_cnt - fbase, fall_l, fall_r);
    end
    // First boundary out of IDLE produces no strobe
    send_frame(32, 16'h1234, 16'hFEDC);
    checks++;
    if (q_l.size() != base) begin
      failures++;
      $display("FAIL idle_first_boundary: got %0d strobes exp 0", q_l.size() - base);
    end
  endtask

`ifdef AD_SOFT_MUTE_EN
  task automatic test_soft_mute();
    int base;
    ad_clk = 1'b0;
    repeat (100) @(negedge mclk);
    base = q_l.size();
    repeat (20) send_frame(32, 16'h7FFF, 16'h8000);
    checks++;
    if (q_l.size() - base != 19) begin
      failures++;
      $display("FAIL soft_strobes: got %0d exp 19", q_l.size() - base);
    end
    for (int k = 0; k < 19; k++)
      chk_entry("soft", base + k, k >= 3, (k >= 3) ? 18 - k : 0, 16'h7FFF, 16'h8000);
  endtask
`endif

  task automatic test_async_reset();
    int base;
    ad_clk = 1'b0;
    repeat (100) @(negedge mclk);
    repeat (5) send_frame(32, 16'h0F0F, 16'h8001);
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre_lock: got locked=%b exp 1", locked);
    end
    @(negedge mclk);
    #2;
    rst_x = 1'b0;
    #1;
    checks++;
    if ({data_l, data_r, valid, locked, mute} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL areset_values: got l=%h r=%h v=%b lk=%b mu=%b exp 0 0 0 0 1",
               data_l, data_r, valid, locked, mute);
    end
    {ad_clk, ad_latch, ad_l, ad_r} = 4'b0;
    repeat (3) @(negedge mclk);
    rst_x = 1'b1;
    base = q_l.size();
    repeat (5) send_frame(32, 16'h0F0F, 16'h8001);
    checks++;
    if (q_l.size() - base != 4) begin
      failures++;
      $display("FAIL areset_strobes: got %0d exp 4", q_l.size() - base);
    end
    for (int k = 0; k < 4; k++) chk_entry("areset_relock", base + k, k == 3, 15, 16'h0F0F, 16'h8001);
  endtask

  initial begin
    #2;
    test_reset();
    test_idle();
    test_lock();
    test_bad_frame();
    test_timeout();
`ifdef AD_SOFT_MUTE_EN
    test_soft_mute();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
